// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - requester, RAM and status signals of the fetch/loader RAM arbiter
interface ram_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_gnt;
  logic              fetch_rvalid;
  logic [DATA_W-1:0] fetch_rdata;

  logic              load_req;
  logic              load_we;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_wdata;
  logic              load_lock;
  logic              load_gnt;
  logic              load_rvalid;
  logic [DATA_W-1:0] load_rdata;

  logic              cpu_halt;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [15:0]       conflict_cnt;

  // master: the requesters plus the RAM macro; slave: the arbiter
  modport master (
    output fetch_req, fetch_addr, load_req, load_we, load_addr, load_wdata, load_lock, ram_rdata,
    input  fetch_gnt, fetch_rvalid, fetch_rdata, load_gnt, load_rvalid, load_rdata,
    input  cpu_halt, ram_en, ram_we, ram_addr, ram_wdata, conflict_cnt
  );

  modport slave (
    input  fetch_req, fetch_addr, load_req, load_we, load_addr, load_wdata, load_lock, ram_rdata,
    output fetch_gnt, fetch_rvalid, fetch_rdata, load_gnt, load_rvalid, load_rdata,
    output cpu_halt, ram_en, ram_we, ram_addr, ram_wdata, conflict_cnt
  );
endinterface

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - single-port RAM arbiter between CPU fetch and program loader with exclusive lock
module ram_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic          CLK,
  input  logic          RST,
  ram_arbiter_if.slave  bus
);

  typedef enum logic {SHARED, LOCKED} state_t;

  state_t            state;
  logic              last_load;
  logic              fetch_pend;
  logic              load_pend;
  logic [DATA_W-1:0] fetch_hold;
  logic [DATA_W-1:0] load_hold;
  logic [15:0]       cnt;

  logic              fetch_gnt_c;
  logic              load_gnt_c;
  logic              contend;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;

  // load_lock is ignored for the grant until the state register has taken it
  always_comb begin
    fetch_gnt_c = 1'b0;
    load_gnt_c  = 1'b0;
    if (!RST) begin
      if (state == LOCKED) begin
        load_gnt_c = bus.load_req;
      end else if (bus.fetch_req && bus.load_req) begin
        fetch_gnt_c = last_load;
        load_gnt_c  = !last_load;
      end else begin
        fetch_gnt_c = bus.fetch_req;
        load_gnt_c  = bus.load_req;
      end
    end
    contend = (state == LOCKED) ? bus.fetch_req : (bus.fetch_req && bus.load_req);
  end

  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    if (load_gnt_c) begin
      addr_mux  = bus.load_addr;
      wdata_mux = bus.load_wdata;
    end else if (fetch_gnt_c) begin
      addr_mux  = bus.fetch_addr;
    end
  end

  assign bus.fetch_gnt    = fetch_gnt_c;
  assign bus.load_gnt     = load_gnt_c;
  assign bus.ram_en       = fetch_gnt_c | load_gnt_c;
  assign bus.ram_we       = load_gnt_c & bus.load_we;
  assign bus.ram_addr     = addr_mux;
  assign bus.ram_wdata    = wdata_mux;
  assign bus.fetch_rvalid = fetch_pend & ~RST;
  assign bus.load_rvalid  = load_pend & ~RST;
  assign bus.fetch_rdata  = (fetch_pend && !RST) ? bus.ram_rdata : fetch_hold;
  assign bus.load_rdata   = (load_pend && !RST) ? bus.ram_rdata : load_hold;
  assign bus.cpu_halt     = (state == LOCKED) & ~RST;
  assign bus.conflict_cnt = cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= SHARED;
      last_load  <= 1'b1;
      fetch_pend <= 1'b0;
      load_pend  <= 1'b0;
      fetch_hold <= '0;
      load_hold  <= '0;
      cnt        <= 16'd0;
    end else begin
      case (state)
        SHARED:  if (bus.load_lock)  state <= LOCKED;
        LOCKED:  if (!bus.load_lock) state <= SHARED;
        default: state <= SHARED;
      endcase

      if (fetch_gnt_c)     last_load <= 1'b0;
      else if (load_gnt_c) last_load <= 1'b1;

      // pending flags follow the requester, not the state, so owed data survives a lock edge
      fetch_pend <= fetch_gnt_c;
      load_pend  <= load_gnt_c & ~bus.load_we;
      if (fetch_pend) fetch_hold <= bus.ram_rdata;
      if (load_pend)  load_hold  <= bus.ram_rdata;

      if (contend && (cnt != 16'hFFFF)) cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter with a transaction-level reference model
module tb_ram_arbiter;
  localparam int AW = 11;
  localparam int DW = 32;

  logic CLK = 1'b0;
  logic RST;

  ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  function automatic logic [31:0] init_word(input int a);
    logic [31:0] t;
    t = a;
    return 32'hA5A5_0000 ^ (t * 32'h9E37_79B1);
  endfunction

  // RAM macro: contents seeded on the first edge, one-cycle read latency
  logic [DW-1:0] mem [0:2047];
  logic          mem_ready = 1'b0;
  always @(posedge CLK) begin
    if (!mem_ready) begin
      for (int i = 0; i < 2048; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else            bus.ram_rdata     <= mem[bus.ram_addr];
    end
  end

  // reference model state
  logic [31:0] ref_mem [0:2047];
  bit          m_locked, m_last_load, m_owe_f, m_owe_l;
  int          m_cnt;
  logic [31:0] m_dat_f, m_dat_l, m_hold_f, m_hold_l;
  bit          e_fg, e_lg;

  // values seen on the DUT in the most recent cycle
  logic        a_fg, a_lg, a_frv, a_lrv, a_halt;
  logic [31:0] a_frd, a_lrd;
  logic [15:0] a_cnt;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input bit do_chk);
    logic [31:0] e_addr, e_wdata;
    bit contend;
    #2;
    e_fg = 0;
    e_lg = 0;
    if (!RST) begin
      if (m_locked) e_lg = bus.load_req;
      else if (bus.fetch_req && bus.load_req) begin
        e_fg = m_last_load;
        e_lg = !m_last_load;
      end else begin
        e_fg = bus.fetch_req;
        e_lg = bus.load_req;
      end
    end
    e_addr  = e_lg ? 32'(bus.load_addr) : (e_fg ? 32'(bus.fetch_addr) : 32'd0);
    e_wdata = e_lg ? bus.load_wdata : 32'd0;

    a_fg   = bus.fetch_gnt;
    a_lg   = bus.load_gnt;
    a_frv  = bus.fetch_rvalid;
    a_lrv  = bus.load_rvalid;
    a_frd  = bus.fetch_rdata;
    a_lrd  = bus.load_rdata;
    a_halt = bus.cpu_halt;
    a_cnt  = bus.conflict_cnt;

    if (do_chk) begin
      chk("fetch_gnt", a_fg, e_fg);
      chk("load_gnt", a_lg, e_lg);
      chk("ram_en", bus.ram_en, e_fg | e_lg);
      chk("ram_we", bus.ram_we, e_lg & bus.load_we);
      chk("ram_addr", 32'(bus.ram_addr), e_addr);
      chk("ram_wdata", bus.ram_wdata, e_wdata);
      chk("fetch_rvalid", a_frv, m_owe_f && !RST);
      chk("load_rvalid", a_lrv, m_owe_l && !RST);
      chk("fetch_rdata", a_frd, (m_owe_f && !RST) ? m_dat_f : m_hold_f);
      chk("load_rdata", a_lrd, (m_owe_l && !RST) ? m_dat_l : m_hold_l);
      chk("cpu_halt", a_halt, m_locked && !RST);
      chk("conflict_cnt", 32'(a_cnt), m_cnt);
    end

    if (RST) begin
      m_locked = 0; m_last_load = 1; m_cnt = 0;
      m_owe_f = 0; m_owe_l = 0; m_hold_f = 0; m_hold_l = 0;
    end else begin
      if (m_owe_f) m_hold_f = m_dat_f;
      if (m_owe_l) m_hold_l = m_dat_l;
      m_owe_f = e_fg;
      if (e_fg) m_dat_f = ref_mem[bus.fetch_addr];
      m_owe_l = e_lg && !bus.load_we;
      if (m_owe_l) m_dat_l = ref_mem[bus.load_addr];
      if (e_lg && bus.load_we) ref_mem[bus.load_addr] = bus.load_wdata;
      if (e_fg) m_last_load = 0;
      else if (e_lg) m_last_load = 1;
      contend = m_locked ? bus.fetch_req : (bus.fetch_req && bus.load_req);
      if (contend && m_cnt < 65535) m_cnt++;
      m_locked = bus.load_lock;
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic rand_reqs(input int pf, input int pl);
    if (!bus.fetch_req && $urandom_range(99) < pf) begin
      bus.fetch_req  = 1;
      bus.fetch_addr = AW'($urandom_range(15));
    end
    if (!bus.load_req && $urandom_range(99) < pl) begin
      bus.load_req   = 1;
      bus.load_we    = 1'($urandom_range(1));
      bus.load_addr  = AW'($urandom_range(15));
      bus.load_wdata = $urandom;
    end
  endtask

  logic [31:0] burst [3];
  bit pat_f [4];

  initial begin
    for (int i = 0; i < 2048; i++) ref_mem[i] = init_word(i);
    burst[0] = 32'h6000_0003; burst[1] = 32'h2000_0001; burst[2] = 32'h1020_0000;
    pat_f[0] = 1; pat_f[1] = 0; pat_f[2] = 1; pat_f[3] = 0;
    RST = 1;
    bus.fetch_req = 0; bus.fetch_addr = '0;
    bus.load_req = 0; bus.load_we = 0; bus.load_addr = '0; bus.load_wdata = '0; bus.load_lock = 0;

    tick(0);
    tick(1);
    chk("reset_fetch_gnt", a_fg, 0);
    chk("reset_load_gnt", a_lg, 0);
    chk("reset_cpu_halt", a_halt, 0);
    chk("reset_conflict_cnt", 32'(a_cnt), 0);

    // contention right after reset: fetch wins the first tie, then alternation
    RST = 0;
    bus.fetch_req = 1; bus.fetch_addr = 11'd3;
    bus.load_req = 1; bus.load_we = 0; bus.load_addr = 11'd4;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("contend_fetch_gnt", a_fg, pat_f[i]);
      chk("contend_load_gnt", a_lg, !pat_f[i]);
    end
    bus.fetch_req = 0; bus.load_req = 0;
    tick(1);
    chk("contend_cnt", 32'(a_cnt), 4);

    // fetch-only read of word 5
    bus.load_req = 1; bus.load_we = 1; bus.load_addr = 11'd5; bus.load_wdata = 32'h2000_0001;
    tick(1);
    bus.load_req = 0;
    bus.fetch_req = 1; bus.fetch_addr = 11'd5;
    tick(1);
    chk("fetch5_gnt", a_fg, 1);
    bus.fetch_req = 0;
    tick(1);
    chk("fetch5_rvalid", a_frv, 1);
    chk("fetch5_rdata", a_frd, 32'h2000_0001);

    // lock rises in the cycle a fetch is granted
    bus.fetch_req = 1; bus.fetch_addr = 11'd5; bus.load_lock = 1;
    tick(1);
    chk("lockedge_fetch_gnt", a_fg, 1);
    bus.fetch_addr = 11'd0;
    tick(1);
    chk("lockedge_rvalid", a_frv, 1);
    chk("lockedge_rdata", a_frd, 32'h2000_0001);
    chk("lockedge_halt", a_halt, 1);
    chk("lockedge_no_fetch", a_fg, 0);

    // loader burst while the CPU keeps requesting
    for (int i = 0; i < 3; i++) begin
      bus.load_req = 1; bus.load_we = 1; bus.load_addr = AW'(i); bus.load_wdata = burst[i];
      tick(1);
      chk("burst_load_gnt", a_lg, 1);
      chk("burst_no_fetch", a_fg, 0);
      chk("burst_halt", a_halt, 1);
    end
    bus.load_req = 0; bus.load_lock = 0;
    tick(1);
    chk("unlock_edge_no_fetch", a_fg, 0);
    for (int i = 0; i < 3; i++) begin
      bus.fetch_req = 1; bus.fetch_addr = AW'(i);
      tick(1);
      chk("readback_gnt", a_fg, 1);
      chk("readback_halt", a_halt, 0);
      bus.fetch_req = 0;
      tick(1);
      chk("readback_rvalid", a_frv, 1);
      chk("readback_rdata", a_frd, burst[i]);
    end

    // reset the cycle after a loader read grant
    bus.load_req = 1; bus.load_we = 0; bus.load_addr = 11'd1;
    tick(1);
    chk("rstread_gnt", a_lg, 1);
    bus.load_req = 0; RST = 1;
    tick(1);
    chk("rstread_rvalid_in_rst", a_lrv, 0);
    RST = 0;
    tick(1);
    chk("rstread_rvalid_after", a_lrv, 0);
    chk("rstread_cnt", 32'(a_cnt), 0);

    // randomized traffic with lock toggles and occasional resets
    for (int n = 0; n < 3000; n++) begin
      rand_reqs(60, 50);
      if ($urandom_range(99) < 3) bus.load_lock = !bus.load_lock;
      RST = ($urandom_range(999) < 5);
      tick(1);
      if (e_fg) bus.fetch_req = 0;
      if (e_lg) bus.load_req = 0;
    end

    // saturation under continuous contention
    RST = 1; bus.load_lock = 0;
    tick(1);
    RST = 0;
    for (int n = 0; n < 65540; n++) begin
      rand_reqs(100, 100);
      tick(1);
      if (e_fg) bus.fetch_req = 0;
      if (e_lg) bus.load_req = 0;
    end
    bus.fetch_req = 0; bus.load_req = 0;
    tick(1);
    chk("saturated_cnt", 32'(a_cnt), 32'h0000_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 11, word-address width (2048 words).
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 CLK  in  1  system clock (16 MHz); all state changes on rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 fetch_req  in  1  CPU instruction-fetch request.
REQ-006 fetch_addr  in  ADDR_W  fetch word address (the pc).
REQ-007 fetch_gnt  out  1  fetch accepted this cycle.
REQ-008 fetch_rvalid  out  1  fetch_rdata valid.
REQ-009 fetch_rdata  out  DATA_W  fetched instruction word.
REQ-010 load_req  in  1  program-loader access request.
REQ-011 load_we  in  1  1 = write, 0 = read.
REQ-012 load_addr  in  ADDR_W  loader word address.
REQ-013 load_wdata  in  DATA_W  loader write data.
REQ-014 load_lock  in  1  loader requests exclusive ownership.
REQ-015 load_gnt  out  1  loader access accepted this cycle.
REQ-016 load_rvalid  out  1  load_rdata valid.
REQ-017 load_rdata  out  DATA_W  loader read data.
REQ-018 cpu_halt  out  1  loader owns RAM exclusively; CPU must stall.
REQ-019 ram_en, ram_we  out  1 each  single-port RAM enable / write enable.
REQ-020 ram_addr  out  ADDR_W, ram_wdata  out  DATA_W  RAM address / write data.
REQ-021 ram_rdata  in  DATA_W  RAM read data, valid one cycle after a read enable.
REQ-022 conflict_cnt  out  16  saturating count of contended cycles.

Function
REQ-023 Grant is combinational from the current-cycle requests and registered state; at most one of fetch_gnt/load_gnt is high per cycle.
REQ-024 ram_en = fetch_gnt | load_gnt; ram_we = load_gnt & load_we; ram_addr/ram_wdata are driven from the granted requester, and are 0 when there is no grant.
REQ-025 Read latency is exactly 1: rvalid goes high on the cycle after the read grant, with rdata = ram_rdata; the write grant produces no rvalid.
REQ-026 rdata holds its last value when rvalid is low.
REQ-027 State machine has two states. SHARED: round-robin arbitration. LOCKED: loader exclusive.
REQ-028 SHARED, single requester: that requester is granted.
REQ-029 SHARED, both requesting: grant the requester not granted most recently (last_owner register); after reset, fetch wins the first tie.
REQ-030 last_owner updates on every grant.
REQ-031 SHARED -> LOCKED on the edge where load_lock=1; LOCKED -> SHARED on the edge where load_lock=0.
REQ-032 A fetch granted in the same cycle load_lock first rises still completes; the lock is effective from the next cycle.
REQ-033 LOCKED: fetch_gnt=0 regardless of fetch_req; load_req is granted every cycle it is high.
REQ-034 cpu_halt = (state==LOCKED); registered, so it is high from the cycle after load_lock rises.
REQ-035 An rvalid owed when the state changes is still delivered to its original requester.
REQ-036 conflict_cnt increments on every SHARED cycle with fetch_req & load_req, and also on every LOCKED cycle with fetch_req; it saturates at 16'hFFFF.
REQ-037 A requester holds req and its address/data until it sees gnt; after gnt it may change them in the next cycle.

Reset
REQ-038 When RST=1 at an edge: state=SHARED, last_owner=load (so fetch wins the first tie), conflict_cnt=0, pending read flags=0, rdata=0.
REQ-039 While RST=1, all gnt, rvalid, ram_en, ram_we and cpu_halt outputs are 0.
REQ-040 Reset mid-access discards any pending rvalid.

Verification
REQ-041 Fetch only: fetch_req=1, addr=5, RAM word 5=32'h20000001 -> fetch_gnt same cycle; fetch_rvalid next cycle with rdata=32'h20000001.
REQ-042 Contention: both requesting 4 cycles after reset -> grants alternate fetch, load, fetch, load; conflict_cnt=4.
REQ-043 Lock burst: load_lock=1, 3 loader writes (addr 0..2, data 32'h60000003, 32'h20000001, 32'h10200000) with fetch_req held -> no fetch_gnt; cpu_halt=1; fetch readback after unlock returns the written values.
REQ-044 Lock edge: load_lock rises in the same cycle a fetch is granted -> that fetch rvalid is delivered next cycle; cpu_halt=1 next cycle; no further fetch_gnt.
REQ-045 Reset mid-read: RST=1 the cycle after load_gnt (read) -> load_rvalid stays 0; conflict_cnt=0.
REQ-046 Saturation: contend for 65540 cycles -> conflict_cnt=16'hFFFF, no wrap.
